// File: rtl/reg_bank_ctrl_pkg.sv
// reg_bank_ctrl_pkg: shared state and pointer codes for the register-bank write controller
package reg_bank_ctrl_pkg;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  typedef enum logic {PTR_A, PTR_B} ptr_t;
endpackage

// File: rtl/reg_bank_ctrl_if.sv
// reg_bank_ctrl_if: requester, clear-sweep and register-bank strobe bundle
interface reg_bank_ctrl_if #(
  parameter int NREG = 4,
  parameter int AW = 2,
  parameter int DW = 4
);
  logic a_req;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic a_ack;
  logic b_req;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic b_ack;
  logic clear_all;
  logic busy;
  logic [NREG-1:0] wr_en;
  logic [DW-1:0] wr_data;
  logic [NREG-1:0] reg_clr;
  modport master (
    output a_req, a_addr, a_data, b_req, b_addr, b_data, clear_all,
    input a_ack, b_ack, busy, wr_en, wr_data, reg_clr
  );
  modport slave (
    input a_req, a_addr, a_data, b_req, b_addr, b_data, clear_all,
    output a_ack, b_ack, busy, wr_en, wr_data, reg_clr
  );
endinterface

// File: rtl/reg_bank_ctrl_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter whose pointer moves past each winner
module rr_arb2
  import reg_bank_ctrl_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic el_a,
  input  logic el_b,
  output logic g_a,
  output logic g_b
);
  ptr_t ptr;
  // a lone eligible requester wins; on a tie the pointer decides
  always_comb begin
    g_a = el_a && (!el_b || ptr == PTR_A);
    g_b = el_b && !g_a;
  end
  // pointer hands priority to the requester that did not just win
  always_ff @(posedge clk or posedge clr)
    if (clr) ptr <= PTR_A;
    else if (g_a || g_b) ptr <= g_a ? PTR_B : PTR_A;
endmodule

// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: shares one register-bank write port between two requesters and runs a clear sweep
module reg_bank_ctrl
  import reg_bank_ctrl_pkg::*;
#(
  parameter int NREG = 4,
  parameter int AW = 2,
  parameter int DW = 4
) (
  input logic clk,
  input logic clr,
  reg_bank_ctrl_if.slave bus
);
  state_t state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic sweep, last, arb_en, el_a, el_b, g_a, g_b;
  logic [AW-1:0] addr;
  logic [NREG-1:0] wr_en_n, reg_clr_n;
  logic [DW-1:0] wr_data_n;
  assign arb_en = state == ST_IDLE && !bus.clear_all;
  assign el_a = arb_en && bus.a_req && !bus.a_ack;
  assign el_b = arb_en && bus.b_req && !bus.b_ack;
  rr_arb2 u_arb (
    .clk  (clk),
    .clr  (clr),
    .el_a (el_a),
    .el_b (el_b),
    .g_a  (g_a),
    .g_b  (g_b)
  );
  // state and sweep index; the IDLE edge that starts a sweep already issues index 0
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= ST_IDLE;
      idx <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
    end
  // sweep runs from clear_all in IDLE until the last register has been cleared
  always_comb begin
    sweep = state == ST_CLEAR || bus.clear_all;
    last = state == ST_CLEAR && idx == AW'(NREG - 1);
    state_n = (sweep && !last) ? ST_CLEAR : ST_IDLE;
    idx_n = (sweep && !last) ? idx + 1'b1 : '0;
  end
  // next values of the registered strobes; out-of-range addresses still ack but never write
  always_comb begin
    addr = g_a ? bus.a_addr : bus.b_addr;
    wr_en_n = ((g_a || g_b) && {1'b0, addr} < (AW + 1)'(NREG)) ? NREG'(1) << addr : '0;
    wr_data_n = g_a ? bus.a_data : g_b ? bus.b_data : bus.wr_data;
    reg_clr_n = sweep ? NREG'(1) << idx : '0;
  end
  // every output is a flop so the bank sees clean one-cycle strobes
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      bus.wr_en <= '0;
      bus.wr_data <= '0;
      bus.reg_clr <= '0;
      bus.busy <= 1'b0;
      bus.a_ack <= 1'b0;
      bus.b_ack <= 1'b0;
    end else begin
      bus.wr_en <= wr_en_n;
      bus.wr_data <= wr_data_n;
      bus.reg_clr <= reg_clr_n;
      bus.busy <= sweep;
      bus.a_ack <= g_a;
      bus.b_ack <= g_b;
    end
endmodule

// File: tb/tb_reg_bank_ctrl.sv
// tb_reg_bank_ctrl: random and directed checks of reg_bank_ctrl against a behavioural model
module tb_reg_bank_ctrl;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int tests = 0;
  int fails = 0;

  reg_bank_ctrl_if #(.NREG(4), .AW(2), .DW(4)) if0 ();
  reg_bank_ctrl_if #(.NREG(3), .AW(2), .DW(4)) if3 ();

  reg_bank_ctrl #(.NREG(4), .AW(2), .DW(4)) dut (.clk(clk), .clr(clr), .bus(if0));
  reg_bank_ctrl #(.NREG(3), .AW(2), .DW(4)) dut3 (.clk(clk), .clr(clr), .bus(if3));

  always #5 clk = ~clk;

  localparam int N = 4;
  int sweep_left;
  bit fav_b;
  logic [3:0] e_wr_en, e_wr_data, e_reg_clr;
  logic e_a_ack, e_b_ack, e_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sweep_left = 0;
    fav_b = 0;
    e_wr_en = 0;
    e_wr_data = 0;
    e_reg_clr = 0;
    e_a_ack = 0;
    e_b_ack = 0;
    e_busy = 0;
  endtask

  task automatic model_step();
    bit ea, eb, wa, wb;
    int addr;
    if (sweep_left > 0) begin
      e_reg_clr = 4'(1 << (N - sweep_left));
      sweep_left--;
      e_busy = 1;
      e_wr_en = 0;
      e_a_ack = 0;
      e_b_ack = 0;
    end else if (if0.clear_all) begin
      e_reg_clr = 4'b0001;
      sweep_left = N - 1;
      e_busy = 1;
      e_wr_en = 0;
      e_a_ack = 0;
      e_b_ack = 0;
    end else begin
      ea = if0.a_req && !e_a_ack;
      eb = if0.b_req && !e_b_ack;
      wa = ea && !(eb && fav_b);
      wb = eb && !wa;
      if (wa || wb) fav_b = wa;
      addr = wa ? int'(if0.a_addr) : int'(if0.b_addr);
      e_wr_en = ((wa || wb) && addr < N) ? 4'(1 << addr) : 4'b0;
      if (wa) e_wr_data = if0.a_data;
      else if (wb) e_wr_data = if0.b_data;
      e_a_ack = wa;
      e_b_ack = wb;
      e_busy = 0;
      e_reg_clr = 0;
    end
  endtask

  task automatic compare();
    chk("wr_en", 32'(if0.wr_en), 32'(e_wr_en));
    chk("wr_data", 32'(if0.wr_data), 32'(e_wr_data));
    chk("reg_clr", 32'(if0.reg_clr), 32'(e_reg_clr));
    chk("acks", {30'b0, if0.a_ack, if0.b_ack}, {30'b0, e_a_ack, e_b_ack});
    chk("busy", 32'(if0.busy), 32'(e_busy));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic chk_zero(input string name);
    chk(name, {if0.wr_en, if0.wr_data, if0.reg_clr, if0.a_ack, if0.b_ack, if0.busy}, 32'd0);
  endtask

  task automatic do_reset();
    #2 clr = 1'b1;
    #1 chk_zero("reset_async");
    model_reset();
    @(posedge clk);
    #2 clr = 1'b0;
  endtask

  task automatic drive_rand();
    if (!if0.a_req || e_a_ack) begin
      if0.a_req = $urandom_range(0, 2) != 0;
      if0.a_addr = 2'($urandom);
      if0.a_data = 4'($urandom);
    end
    if (!if0.b_req || e_b_ack) begin
      if0.b_req = $urandom_range(0, 2) != 0;
      if0.b_addr = 2'($urandom);
      if0.b_data = 4'($urandom);
    end
    if0.clear_all = $urandom_range(0, 19) == 0;
  endtask

  initial begin
    {if0.a_req, if0.a_addr, if0.a_data, if0.b_req, if0.b_addr, if0.b_data, if0.clear_all} = '0;
    {if3.a_req, if3.a_addr, if3.a_data, if3.b_req, if3.b_addr, if3.b_data, if3.clear_all} = '0;
    model_reset();
    #12 chk_zero("reset_state");
    clr = 1'b0;
    tick();
    chk("idle_no_strobe", 32'(if0.wr_en | if0.reg_clr), 0);

    if0.a_req = 1; if0.a_addr = 2; if0.a_data = 4'hA;
    tick();
    chk("solo_a_first", {if0.wr_en, if0.wr_data, 3'b0, if0.a_ack}, {4'b0100, 4'hA, 3'b0, 1'b1});
    tick();
    chk("solo_a_gap", {if0.wr_en, 3'b0, if0.a_ack}, 8'h00);
    tick();
    chk("solo_a_repeat", {if0.wr_en, 3'b0, if0.a_ack}, {4'b0100, 4'h1});
    if0.a_req = 0;
    tick();

    do_reset();
    if0.a_req = 1; if0.a_addr = 1; if0.a_data = 4'h3;
    if0.b_req = 1; if0.b_addr = 3; if0.b_data = 4'hC;
    tick();
    chk("cont_1", {if0.wr_en, if0.wr_data, 2'b0, if0.a_ack, if0.b_ack}, {4'b0010, 4'h3, 4'b0010});
    tick();
    chk("cont_2", {if0.wr_en, if0.wr_data, 2'b0, if0.a_ack, if0.b_ack}, {4'b1000, 4'hC, 4'b0001});
    tick();
    chk("cont_3", {if0.wr_en, 2'b0, if0.a_ack, if0.b_ack}, {4'b0010, 4'b0010});
    if0.a_req = 0;
    tick();
    if0.b_req = 0;
    tick();

    if0.a_req = 1; if0.a_addr = 0; if0.a_data = 4'h5; if0.clear_all = 1;
    tick();
    if0.clear_all = 0;
    chk("sweep_0", {if0.reg_clr, 1'b0, if0.busy, if0.a_ack, if0.b_ack}, {4'b0001, 4'b0100});
    tick();
    chk("sweep_1", {if0.reg_clr, 3'b0, if0.busy}, {4'b0010, 4'b0001});
    tick();
    chk("sweep_2", {if0.reg_clr, 3'b0, if0.busy}, {4'b0100, 4'b0001});
    tick();
    chk("sweep_3", {if0.reg_clr, 2'b0, if0.busy, if0.a_ack}, {4'b1000, 4'b0010});
    tick();
    chk("after_sweep", {if0.reg_clr, if0.wr_en, 2'b0, if0.busy, if0.a_ack}, {8'b0000_0001, 4'b0001});
    if0.a_req = 0;
    tick();

    if0.clear_all = 1;
    tick();
    if0.clear_all = 0;
    tick();
    tick();
    chk("abort_idx2", 32'(if0.reg_clr), 32'b0100);
    #2 clr = 1'b1;
    #1 chk("abort_clear", {if0.reg_clr, 3'b0, if0.busy}, 8'h00);
    model_reset();
    @(posedge clk);
    #2 clr = 1'b0;
    tick();
    tick();
    chk("no_resume", {if0.reg_clr, 3'b0, if0.busy}, 8'h00);
    if0.a_req = 1; if0.a_addr = 3; if0.a_data = 4'h7;
    if0.b_req = 1; if0.b_addr = 0; if0.b_data = 4'h9;
    tick();
    chk("ptr_a_after_reset", {if0.a_ack, if0.b_ack}, 2'b10);
    tick();
    if0.a_req = 0; if0.b_req = 0;
    tick();

    if3.a_req = 1; if3.a_addr = 3; if3.a_data = 4'h6;
    @(posedge clk);
    #1 chk("nreg3_drop", {if3.wr_en, 3'b0, if3.a_ack}, {3'b000, 4'h1});
    if3.a_addr = 2;
    @(posedge clk);
    @(posedge clk);
    #1 chk("nreg3_valid", {if3.wr_en, 3'b0, if3.a_ack}, {3'b100, 4'h1});
    if3.a_req = 0;

    for (int i = 0; i < 3000; i++) begin
      drive_rand();
      if (i == 1500) do_reset();
      tick();
      tests++;
      if ($countones(if0.wr_en) > 1 || $countones(if0.reg_clr) > 1 ||
          (if0.wr_en != 0 && if0.reg_clr != 0) || (if0.a_ack && if0.b_ack)) begin
        fails++;
        $display("FAIL invariant: wr_en=%b reg_clr=%b a_ack=%b b_ack=%b", if0.wr_en, if0.reg_clr, if0.a_ack, if0.b_ack);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
